alu_wb_stage: RTL and testbench

ALU_WB_STAGE -- requirements
Module: alu_wb_stage

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_cond_eval.sv | 25 ++
 rtl/alu_wb_stage.sv | 120 ++++++++++++
 tb/tb_alu_wb_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU writeback definitions: flag bit positions, branch
// condition codes and the writeback buffer state encoding.
package alu_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_MI = 3'b011;
  localparam logic [2:0] COND_CS = 3'b100;
  localparam logic [2:0] COND_VS = 3'b101;
  localparam logic [2:0] COND_LT = 3'b110;
  localparam logic [2:0] COND_NV = 3'b111;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/alu_cond_eval.sv
// Branch condition evaluation on the committed {N,V,C,Z} flags.
// Purely combinational.
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] cond_sel,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    unique case (cond_sel)
      COND_AL: cond_true = 1'b1;
      COND_EQ: cond_true = flags[FLAG_Z];
      COND_NE: cond_true = ~flags[FLAG_Z];
      COND_MI: cond_true = flags[FLAG_N];
      COND_CS: cond_true = flags[FLAG_C];
      COND_VS: cond_true = flags[FLAG_V];
      COND_LT: cond_true = flags[FLAG_N] ^ flags[FLAG_V];
      COND_NV: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: 2-entry result/flag buffer with flag commit on pop.
// Optional branch condition logic enabled by macro BRANCH_COND_EN.
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_y,
  input  logic              in_n,
  input  logic              in_v,
  input  logic              in_c,
  input  logic              in_z,
  input  logic              in_flag_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y,
  output logic [3:0]        flags,
  input  logic [2:0]        cond_sel,
  output logic              cond_true,
  output logic [1:0]        occupancy
);

  logic [1:0]        state;
  logic [1:0]        state_n;
  logic [DATA_W-1:0] y0, y1;
  logic [3:0]        f0, f1;
  logic              we0, we1;
  logic [3:0]        flags_q;
  logic [3:0]        in_fl;
  logic              push;
  logic              pop;

  assign in_fl     = {in_n, in_v, in_c, in_z};
  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_y     = y0;
  assign flags     = flags_q;
  assign occupancy = state;

  always_comb begin
    state_n = state;
    case (state)
      ST_EMPTY: if (push) state_n = ST_ONE;
      ST_ONE: begin
        if (push && !pop) state_n = ST_FULL;
        else if (pop && !push) state_n = ST_EMPTY;
      end
      ST_FULL: if (pop) state_n = ST_ONE;
      default: state_n = ST_EMPTY;
    endcase
  end

  // Entry 0 is always the head; entry 1 only holds the second of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      y0      <= '0;
      y1      <= '0;
      f0      <= '0;
      f1      <= '0;
      we0     <= 1'b0;
      we1     <= 1'b0;
      flags_q <= '0;
    end else begin
      state <= state_n;
      if (pop && we0) flags_q <= f0;
      case (state)
        ST_EMPTY: begin
          if (push) begin
            y0  <= in_y;
            f0  <= in_fl;
            we0 <= in_flag_we;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            y0  <= in_y;
            f0  <= in_fl;
            we0 <= in_flag_we;
          end else if (push) begin
            y1  <= in_y;
            f1  <= in_fl;
            we1 <= in_flag_we;
          end
        end
        ST_FULL: begin
          if (pop) begin
            y0  <= y1;
            f0  <= f1;
            we0 <= we1;
          end
        end
        default: ;
      endcase
    end
  end

  logic unused_depth;
  assign unused_depth = (DEPTH != 2);

`ifdef BRANCH_COND_EN
  alu_cond_eval u_cond (
    .flags     (flags_q),
    .cond_sel  (cond_sel),
    .cond_true (cond_true)
  );
`else
  logic unused_cond;
  assign unused_cond = ^cond_sel;
  assign cond_true   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed table-driven bench for alu_wb_stage plus reset
// corner sequences; honours BRANCH_COND_EN for cond_true expectations.
module tb_alu_wb_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_y;
  logic       in_n, in_v, in_c, in_z;
  logic       in_flag_we;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic [3:0] flags;
  logic [2:0] cond_sel;
  logic       cond_true;
  logic [1:0] occupancy;

  int checks;
  int failures;

  alu_wb_stage #(.DATA_W(8), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_y       (in_y),
    .in_n       (in_n),
    .in_v       (in_v),
    .in_c       (in_c),
    .in_z       (in_z),
    .in_flag_we (in_flag_we),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .flags      (flags),
    .cond_sel   (cond_sel),
    .cond_true  (cond_true),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] y;
    logic [3:0] f;
    logic       we;
    logic       ordy;
    logic [2:0] sel;
    logic [1:0] e_occ;
    logic       e_ov;
    logic       chk_y;
    logic [7:0] e_y;
    logic [3:0] e_fl;
    logic       e_ir;
  } vec_t;

  vec_t vt[$];

  function automatic logic mcond(input logic [3:0] f, input logic [2:0] s);
`ifdef BRANCH_COND_EN
    case (s)
      3'd0: return 1'b1;
      3'd1: return f[0];
      3'd2: return ~f[0];
      3'd3: return f[3];
      3'd4: return f[1];
      3'd5: return f[2];
      3'd6: return f[3] ^ f[2];
      default: return 1'b0;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  function automatic vec_t mk(
    input logic iv, input logic [7:0] y, input logic [3:0] f,
    input logic we, input logic ordy, input logic [2:0] sel,
    input logic [1:0] e_occ, input logic e_ov, input logic chk_y,
    input logic [7:0] e_y, input logic [3:0] e_fl, input logic e_ir);
    vec_t v;
    v.iv = iv; v.y = y; v.f = f; v.we = we; v.ordy = ordy;
    v.sel = sel; v.e_occ = e_occ; v.e_ov = e_ov; v.chk_y = chk_y;
    v.e_y = e_y; v.e_fl = e_fl; v.e_ir = e_ir;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] y,
                       input logic [3:0] f, input logic we,
                       input logic ordy, input logic [2:0] sel);
    in_valid   = iv;
    in_y       = y;
    {in_n, in_v, in_c, in_z} = f;
    in_flag_we = we;
    out_ready  = ordy;
    cond_sel   = sel;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 3'd0);

    // iv  y      f     we ordy sel  occ ov cy e_y   fl    ir
    vt.push_back(mk(1, 8'h00, 4'h1, 1, 0, 3'd1, 1, 1, 1, 8'h00, 4'h0, 1));
    vt.push_back(mk(0, 8'h00, 4'h0, 0, 1, 3'd1, 0, 0, 0, 8'h00, 4'h1, 1));
    vt.push_back(mk(1, 8'hA5, 4'h0, 0, 0, 3'd2, 1, 1, 1, 8'hA5, 4'h1, 1));
    vt.push_back(mk(1, 8'h3C, 4'h0, 0, 0, 3'd2, 2, 1, 1, 8'hA5, 4'h1, 0));
    vt.push_back(mk(1, 8'hFF, 4'hF, 1, 0, 3'd0, 2, 1, 1, 8'hA5, 4'h1, 0));
    vt.push_back(mk(0, 8'h00, 4'h0, 0, 1, 3'd0, 1, 1, 1, 8'h3C, 4'h1, 1));
    vt.push_back(mk(0, 8'h00, 4'h0, 0, 1, 3'd1, 0, 0, 0, 8'h00, 4'h1, 1));
    vt.push_back(mk(1, 8'h11, 4'h0, 0, 0, 3'd1, 1, 1, 1, 8'h11, 4'h1, 1));
    vt.push_back(mk(1, 8'h22, 4'h0, 0, 1, 3'd1, 1, 1, 1, 8'h22, 4'h1, 1));
    vt.push_back(mk(0, 8'h00, 4'h0, 0, 1, 3'd2, 0, 0, 0, 8'h00, 4'h1, 1));
    vt.push_back(mk(1, 8'h77, 4'h8, 1, 0, 3'd3, 1, 1, 1, 8'h77, 4'h1, 1));
    vt.push_back(mk(1, 8'h88, 4'h0, 0, 1, 3'd6, 1, 1, 1, 8'h88, 4'h8, 1));
    vt.push_back(mk(0, 8'h00, 4'h0, 0, 1, 3'd7, 0, 0, 0, 8'h00, 4'h8, 1));
    for (int s = 0; s < 8; s++)
      vt.push_back(mk(0, 8'h00, 4'h0, 0, 0, 3'(s), 0, 0, 0, 8'h00, 4'h8, 1));

    #12;
    chk("rst_occ", occupancy, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_flags", flags, 0);
    chk("rst_ir", in_ready, 1);
    chk("rst_cond", cond_true, mcond(4'h0, 3'd0));

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i].iv, vt[i].y, vt[i].f, vt[i].we, vt[i].ordy, vt[i].sel);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_occ", i), occupancy, vt[i].e_occ);
      chk($sformatf("v%0d_ov", i), out_valid, vt[i].e_ov);
      if (vt[i].chk_y) chk($sformatf("v%0d_y", i), out_y, vt[i].e_y);
      chk($sformatf("v%0d_flags", i), flags, vt[i].e_fl);
      chk($sformatf("v%0d_ir", i), in_ready, vt[i].e_ir);
      chk($sformatf("v%0d_cond", i), cond_true,
          mcond(vt[i].e_fl, vt[i].sel));
    end

    // Fill with flag-committing entries, then reset while FULL.
    @(negedge clk);
    drive(1'b1, 8'h01, 4'h5, 1'b1, 1'b0, 3'd0);
    @(negedge clk);
    drive(1'b1, 8'h02, 4'h5, 1'b1, 1'b0, 3'd0);
    @(posedge clk);
    #1;
    chk("full_occ", occupancy, 2);
    @(negedge clk);
    drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 3'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_occ", occupancy, 0);
    chk("midrst_ov", out_valid, 0);
    chk("midrst_flags", flags, 0);
    chk("midrst_ir", in_ready, 1);
    @(posedge clk);
    #1;
    chk("midrst_hold_flags", flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h5A, 4'h2, 1'b1, 1'b0, 3'd4);
    #1;
    chk("nobypass_ov", out_valid, 0);
    chk("post_rst_ir", in_ready, 1);
    @(posedge clk);
    #1;
    chk("first_push_occ", occupancy, 1);
    chk("first_push_y", out_y, 8'h5A);
    chk("first_push_flags", flags, 0);
    @(negedge clk);
    drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 3'd4);
    @(posedge clk);
    #1;
    chk("commit_flags", flags, 4'h2);
    chk("commit_cond", cond_true, mcond(4'h2, 3'd4));
    chk("commit_occ", occupancy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
